idex_skid_reg: RTL and testbench
================================

Name: idex_skid_reg

Overview:
- Parametrised successor to the fixed ID/EX pipeline register.
- Carries decode-stage results (register/memory write enables, two operand values, destination register index) into EX through a 2-entry skid buffer.
- Uses a valid/ready handshake, so EX back-pressure stalls ID without a combinational ready path.
- Adds a pipeline flush and a saturating stall-cycle counter for performance monitoring.

Parameters:
- DATA_W, 64, width of each operand field.
- REG_AW, 5, width of the destination register index.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- flush  in  1  discard all buffered entries.
- in_valid  in  1  ID presents a valid bundle.
- in_ready  out  1  stage can accept a bundle; registered.
- WRegEn_in  in  1  register-write enable.
- WMemEn_in  in  1  memory-write enable.
- R1out_in  in  DATA_W  operand 1.
- R2out_in  in  DATA_W  operand 2.
- WReg1_in  in  REG_AW  destination register index.
- out_valid  out  1  EX-side bundle valid.
- out_ready  in  1  EX accepts bundle.
- WRegEn_out  out  1  registered; forced 0 whenever out_valid=0.
- WMemEn_out  out  1  registered; forced 0 whenever out_valid=0.
- R1out_out  out  DATA_W  operand 1 to EX.
- R2out_out  out  DATA_W  operand 2 to EX.
- WReg1_out  out  REG_AW  destination index to EX.
- occupancy  out  2  number of valid entries (0..2).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0; saturating.

Behaviour:
- Reset (async, immediate):
  - out_valid=0, occupancy=0, stall_cnt=0, in_ready=1.
  - All data and enable outputs = 0; skid entry invalid and its fields = 0.
- Transfers:
  - Accept = in_valid & in_ready.
  - Drain = out_valid & out_ready.
- Storage:
  - main entry drives outputs directly.
  - skid entry holds one overflow bundle.
- Each field is captured independently. WRegEn_out must come from WRegEn_in, not from any other input.
- Per-cycle update, no flush:
  - main empty, or draining with skid empty: accept loads main; no accept and draining empties main.
  - main full, not draining, accept: bundle goes to skid; in_ready=0 next cycle.
  - draining with skid full: skid moves to main, skid empties, in_ready=1 next cycle. No accept is possible this cycle because in_ready=0.
- Latency:
  - Accept at edge N gives out_valid=1 with those fields after edge N, when main was empty or draining.
  - Throughput is 1 bundle/cycle while out_ready=1.
- in_ready is always registered: it equals "skid empty" as computed at the previous edge.
- Flush:
  - At the edge where flush=1, main and skid become invalid and enable outputs become 0.
  - in_ready=1 next cycle; occupancy=0.
  - Flush wins over a simultaneous accept; the incoming bundle is dropped.
  - Operand and index outputs hold their last values; enables are the only qualifiers EX may trust.
  - A drain in the same cycle as flush counts as completed from EX's side.
- occupancy equals main valid + skid valid, registered.
- stall_cnt:
  - Increments by 1 on each edge where out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1.
  - Cleared only by RST; flush does not clear it.
- Reset asserted mid-transfer: all state clears immediately; no bundle is delivered after reset release without a new accept.
- Parameter rules: no arithmetic on data fields; widths pass through unchanged.

Test Plan:
- Reset, then in_valid=1, WRegEn_in=1, WMemEn_in=0, R1out_in=64'h1234, R2out_in=64'h5678, WReg1_in=5'd7, out_ready=1 → one cycle later out_valid=1, WRegEn_out=1, WMemEn_out=0, R1out_out=64'h1234, R2out_out=64'h5678, WReg1_out=7.
- Stream bundles A,B,C on consecutive cycles with out_ready=0 from the cycle A is accepted → A held at outputs, B lands in skid, in_ready=0, occupancy=2, C not accepted. Raise out_ready → A, B, C emerge in order with no loss or duplication.
- out_valid=1 with out_ready=0 for 5 cycles and CNT_W=3 → stall_cnt=5. Hold 10 cycles → stall_cnt saturates at 7.
- occupancy=2, assert flush with in_valid=1 → next cycle out_valid=0, WRegEn_out=0, WMemEn_out=0, occupancy=0, in_ready=1; the flushed-cycle input never appears.
- Assert RST asynchronously mid-cycle while occupancy=1 → outputs zero before the next CLK edge, in_ready=1, stall_cnt=0.
- Sweep a random in_valid/out_ready pattern for 10k cycles against a FIFO scoreboard → output order matches input order exactly; in_ready never depends combinationally on out_ready.

Source files
------------

// File: rtl/idex_skid_reg.sv
// ID/EX pipeline register with a 2-entry skid buffer, flush and stall counter.
// Latency: 1 cycle from accept to out_valid; sustains 1 bundle/cycle while out_ready=1.
// Backpressure: in_ready is registered (skid empty); a full skid deasserts it, no comb path from out_ready.
//
// Ports:
//   CLK, RST            clock, async active-high reset
//   flush               drop main and skid entries (enables cleared, operands held)
//   in_valid/in_ready   ID-side handshake; bundle = WRegEn/WMemEn/R1out/R2out/WReg1 *_in
//   out_valid/out_ready EX-side handshake; bundle = *_out, enables forced 0 when invalid
//   occupancy           registered count of valid entries (0..2)
//   stall_cnt           saturating count of edges with out_valid=1 and out_ready=0
module idex_skid_reg #(
    parameter int DATA_W = 64,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              WRegEn_in,
    input  logic              WMemEn_in,
    input  logic [DATA_W-1:0] R1out_in,
    input  logic [DATA_W-1:0] R2out_in,
    input  logic [REG_AW-1:0] WReg1_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              WRegEn_out,
    output logic              WMemEn_out,
    output logic [DATA_W-1:0] R1out_out,
    output logic [DATA_W-1:0] R2out_out,
    output logic [REG_AW-1:0] WReg1_out,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic              wreg_en;
        logic              wmem_en;
        logic [DATA_W-1:0] r1;
        logic [DATA_W-1:0] r2;
        logic [REG_AW-1:0] wreg1;
    } bundle_t;

    bundle_t in_b;
    bundle_t main_q, main_d;
    bundle_t skid_q, skid_d;
    logic    main_vld, main_vld_d;
    logic    skid_vld, skid_vld_d;
    logic    accept;
    logic    drain;

    assign in_b.wreg_en = WRegEn_in;
    assign in_b.wmem_en = WMemEn_in;
    assign in_b.r1      = R1out_in;
    assign in_b.r2      = R2out_in;
    assign in_b.wreg1   = WReg1_in;

    assign accept = in_valid & in_ready;
    assign drain  = main_vld & out_ready;

    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld;
        skid_vld_d = skid_vld;
        if (flush) begin
            // Operand/index fields keep their last values; only the enables
            // are cleared so EX sees no side effects from stale data.
            main_vld_d     = 1'b0;
            skid_vld_d     = 1'b0;
            main_d.wreg_en = 1'b0;
            main_d.wmem_en = 1'b0;
            skid_d.wreg_en = 1'b0;
            skid_d.wmem_en = 1'b0;
        end else if (!main_vld || (drain && !skid_vld)) begin
            if (accept) begin
                main_d     = in_b;
                main_vld_d = 1'b1;
            end else if (drain) begin
                main_vld_d     = 1'b0;
                main_d.wreg_en = 1'b0;
                main_d.wmem_en = 1'b0;
            end
        end else if (drain) begin
            // Skid is full here, so in_ready is low and no accept can collide.
            main_d         = skid_q;
            main_vld_d     = 1'b1;
            skid_vld_d     = 1'b0;
            skid_d.wreg_en = 1'b0;
            skid_d.wmem_en = 1'b0;
        end else if (accept) begin
            skid_d     = in_b;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            main_q    <= '0;
            skid_q    <= '0;
            main_vld  <= 1'b0;
            skid_vld  <= 1'b0;
            in_ready  <= 1'b1;
            occupancy <= 2'd0;
            stall_cnt <= '0;
        end else begin
            main_q    <= main_d;
            skid_q    <= skid_d;
            main_vld  <= main_vld_d;
            skid_vld  <= skid_vld_d;
            in_ready  <= ~skid_vld_d;
            occupancy <= {1'b0, main_vld_d} + {1'b0, skid_vld_d};
            if (main_vld && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign out_valid  = main_vld;
    assign WRegEn_out = main_q.wreg_en;
    assign WMemEn_out = main_q.wmem_en;
    assign R1out_out  = main_q.r1;
    assign R2out_out  = main_q.r2;
    assign WReg1_out  = main_q.wreg1;

endmodule

// File: tb/tb_idex_skid_reg.sv
module tb_idex_skid_reg;

    localparam int DATA_W = 64;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 3;

    logic              CLK = 1'b0;
    logic              RST;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              WRegEn_in;
    logic              WMemEn_in;
    logic [DATA_W-1:0] R1out_in;
    logic [DATA_W-1:0] R2out_in;
    logic [REG_AW-1:0] WReg1_in;
    logic              out_valid;
    logic              out_ready;
    logic              WRegEn_out;
    logic              WMemEn_out;
    logic [DATA_W-1:0] R1out_out;
    logic [DATA_W-1:0] R2out_out;
    logic [REG_AW-1:0] WReg1_out;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    idex_skid_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .WRegEn_in(WRegEn_in), .WMemEn_in(WMemEn_in),
        .R1out_in(R1out_in), .R2out_in(R2out_in), .WReg1_in(WReg1_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .WRegEn_out(WRegEn_out), .WMemEn_out(WMemEn_out),
        .R1out_out(R1out_out), .R2out_out(R2out_out), .WReg1_out(WReg1_out),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic me,
                         input logic [63:0] r1, input logic [63:0] r2, input logic [4:0] wr);
        in_valid  = v;
        WRegEn_in = we;
        WMemEn_in = me;
        R1out_in  = r1;
        R2out_in  = r2;
        WReg1_in  = wr;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #1;
        RST = 1'b0;
    endtask

    // Payload derived from a sequence number so every field differs independently.
    function automatic logic [63:0] pl_r1(input int s);
        return 64'hA000_0000_0000_0000 | 64'(s);
    endfunction
    function automatic logic [63:0] pl_r2(input int s);
        return ~(64'(s) * 64'd3);
    endfunction

    int                q[$];
    int                seq;
    int                exp_s;
    logic              rv;
    logic              rr;
    logic [4:0]        s5;

    initial begin
        RST = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
        step();
        step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_stall", 64'(stall_cnt), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_wregen", 64'(WRegEn_out), 64'd0);
        chk("rst_r1", R1out_out, 64'd0);
        RST = 1'b0;

        // Single bundle, one-cycle latency
        drive(1'b1, 1'b1, 1'b0, 64'h1234, 64'h5678, 5'd7);
        out_ready = 1'b1;
        step();
        drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_wregen", 64'(WRegEn_out), 64'd1);
        chk("t1_wmemen", 64'(WMemEn_out), 64'd0);
        chk("t1_r1", R1out_out, 64'h1234);
        chk("t1_r2", R2out_out, 64'h5678);
        chk("t1_wreg1", 64'(WReg1_out), 64'd7);
        step();
        chk("t1_drained", 64'(out_valid), 64'd0);
        chk("t1_en_cleared", 64'(WRegEn_out), 64'd0);

        // A, B, C streamed into a stalled EX
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 64'hA, 64'hAA, 5'd1);
        step();
        drive(1'b1, 1'b1, 1'b0, 64'hB, 64'hBB, 5'd2);
        step();
        drive(1'b1, 1'b1, 1'b1, 64'hC, 64'hCC, 5'd3);
        chk("t2_occ2", 64'(occupancy), 64'd2);
        chk("t2_in_ready0", 64'(in_ready), 64'd0);
        chk("t2_hold_a", R1out_out, 64'hA);
        chk("t2_a_wmemen", 64'(WMemEn_out), 64'd1);
        step();
        chk("t2_c_refused", 64'(occupancy), 64'd2);
        chk("t2_still_a", R1out_out, 64'hA);
        out_ready = 1'b1;
        #1;
        chk("t2_no_comb_ready", 64'(in_ready), 64'd0);
        step();
        chk("t2_b_out", R1out_out, 64'hB);
        chk("t2_b_wreg1", 64'(WReg1_out), 64'd2);
        chk("t2_ready_back", 64'(in_ready), 64'd1);
        step();
        drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
        chk("t2_c_out", R1out_out, 64'hC);
        chk("t2_c_r2", R2out_out, 64'hCC);
        step();
        chk("t2_empty", 64'(out_valid), 64'd0);
        chk("t2_stall", 64'(stall_cnt), 64'd2);

        // Stall counter: 5 stalled edges, then saturation at 7
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 64'hD, 64'hDD, 5'd4);
        step();
        drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
        chk("t3_start", 64'(stall_cnt), 64'd0);
        repeat (5) step();
        chk("t3_five", 64'(stall_cnt), 64'd5);
        repeat (5) step();
        chk("t3_sat", 64'(stall_cnt), 64'd7);
        chk("t3_held", R1out_out, 64'hD);

        // Flush with both entries full and a pending input
        drive(1'b1, 1'b0, 1'b0, 64'hE, 64'hEE, 5'd5);
        step();
        chk("t4_occ2", 64'(occupancy), 64'd2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
        chk("t4_valid0", 64'(out_valid), 64'd0);
        chk("t4_wregen0", 64'(WRegEn_out), 64'd0);
        chk("t4_wmemen0", 64'(WMemEn_out), 64'd0);
        chk("t4_occ0", 64'(occupancy), 64'd0);
        chk("t4_ready1", 64'(in_ready), 64'd1);
        chk("t4_stall_kept", 64'(stall_cnt), 64'd7);
        chk("t4_r1_hold", R1out_out, 64'hD);

        // Flush beats a simultaneous accept
        drive(1'b1, 1'b1, 1'b0, 64'hF, 64'hFF, 5'd6);
        step();
        chk("t4b_occ1", 64'(occupancy), 64'd1);
        drive(1'b1, 1'b1, 1'b1, 64'h77, 64'h777, 5'd9);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
        chk("t4b_valid0", 64'(out_valid), 64'd0);
        chk("t4b_occ0", 64'(occupancy), 64'd0);
        step();
        chk("t4b_dropped", 64'(out_valid), 64'd0);
        chk("t4b_r1_not_g", R1out_out, 64'hF);

        // Asynchronous reset mid-cycle with one entry held
        drive(1'b1, 1'b1, 1'b1, 64'h99, 64'h999, 5'd10);
        step();
        drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
        chk("t5_occ1", 64'(occupancy), 64'd1);
        #2;
        RST = 1'b1;
        #1;
        chk("t5_valid0", 64'(out_valid), 64'd0);
        chk("t5_r1_0", R1out_out, 64'd0);
        chk("t5_wregen0", 64'(WRegEn_out), 64'd0);
        chk("t5_ready1", 64'(in_ready), 64'd1);
        chk("t5_stall0", 64'(stall_cnt), 64'd0);
        RST = 1'b0;
        step();
        chk("t5_no_ghost", 64'(out_valid), 64'd0);

        // Random handshake sweep against a FIFO scoreboard
        seq = 1;
        for (int i = 0; i < 10000; i++) begin
            rv = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 3) != 0);
            s5 = 5'(seq);
            drive(rv, s5[0], s5[2], pl_r1(seq), pl_r2(seq), s5);
            out_ready = rr;
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_unexpected", R1out_out, 64'd0);
                end else begin
                    exp_s = q.pop_front();
                    s5 = 5'(exp_s);
                    chk("rnd_r1", R1out_out, pl_r1(exp_s));
                    chk("rnd_r2", R2out_out, pl_r2(exp_s));
                    chk("rnd_fields", {59'd0, WRegEn_out, WMemEn_out, WReg1_out[2:0]},
                        {59'd0, s5[0], s5[2], s5[2:0]});
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(seq);
                seq++;
            end
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (out_valid && q.size() != 0) begin
                exp_s = q.pop_front();
                chk("rnd_tail_r1", R1out_out, pl_r1(exp_s));
            end
            step();
        end
        chk("rnd_queue_empty", 64'(q.size()), 64'd0);
        chk("rnd_final_empty", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
